// File: rtl/fetch_decode_pipe_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_decode_pipe_reg_pkg
// Brief  : Shared pipeline-register state encoding and default NOP encoding.
// Rev    : 1.0
// ============================================================================
package fetch_decode_pipe_reg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    // All-zero NOP, shared with the decode/execute latches.
    localparam logic [31:0] c_nop_default = 32'h0000_0000;

endpackage : fetch_decode_pipe_reg_pkg
`default_nettype wire

// File: rtl/fetch_decode_pipe_reg_entry.sv
`default_nettype none
// ============================================================================
// Module : pipe_entry_reg
// Brief  : One pipeline entry: valid flag plus instruction/PC payload.
// Rev    : 1.0
// ============================================================================
module pipe_entry_reg #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [PC_W-1:0]    o_pc
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc;

    // Clear wins over load so a flush always empties the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule : pipe_entry_reg
`default_nettype wire

// File: rtl/fetch_decode_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module : fetch_decode_pipe_reg
// Brief  : Fetch->decode pipeline register with handshake, flush, bubble
//          forcing and optional 2-entry skid buffer.
// Rev    : 1.0
// ============================================================================
module fetch_decode_pipe_reg
    import fetch_decode_pipe_reg_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(c_nop_default),
    parameter int                 SKID_EN   = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy
);

    pipe_state_t        r_state;
    pipe_state_t        w_state_next;
    logic               w_in_ready;
    logic               w_in_fire;
    logic               w_out_fire;
    logic               w_main_load;
    logic               w_main_clear;
    logic               w_main_sel_skid;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_main_valid;
    logic [INSTR_W-1:0] w_main_instr;
    logic [PC_W-1:0]    w_main_pc;
    logic               w_skid_valid;
    logic [INSTR_W-1:0] w_skid_instr;
    logic [PC_W-1:0]    w_skid_pc;

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = w_main_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_main_load     = 1'b0;
        w_main_clear    = 1'b0;
        w_main_sel_skid = 1'b0;
        w_skid_load     = 1'b0;
        w_skid_clear    = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_next = ST_FULL;
                    w_main_load  = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    // Without a skid entry in_ready already implies out_fire.
                    if (SKID_EN != 0) begin
                        w_state_next = ST_SKID;
                        w_skid_load  = 1'b1;
                    end else begin
                        w_main_load  = 1'b1;
                    end
                end else if (w_out_fire) begin
                    w_state_next = ST_EMPTY;
                    w_main_clear = 1'b1;
                end
            end
            ST_SKID: begin
                if (w_out_fire) begin
                    w_state_next    = ST_FULL;
                    w_main_load     = 1'b1;
                    w_main_sel_skid = 1'b1;
                    w_skid_clear    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_EMPTY;
                w_main_clear = 1'b1;
                w_skid_clear = 1'b1;
            end
        endcase
        if (flush) begin
            w_state_next = ST_EMPTY;
            w_main_load  = 1'b0;
            w_skid_load  = 1'b0;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end
    end

    pipe_entry_reg #(
        .INSTR_W (INSTR_W),
        .PC_W    (PC_W)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_instr (w_main_sel_skid ? w_skid_instr : in_instr),
        .i_pc    (w_main_sel_skid ? w_skid_pc    : in_pc),
        .o_valid (w_main_valid),
        .o_instr (w_main_instr),
        .o_pc    (w_main_pc)
    );

    generate
        if (SKID_EN != 0) begin : g_skid
            logic r_in_ready;

            pipe_entry_reg #(
                .INSTR_W (INSTR_W),
                .PC_W    (PC_W)
            ) u_skid (
                .clk     (clk),
                .reset   (reset),
                .i_load  (w_skid_load),
                .i_clear (w_skid_clear),
                .i_instr (in_instr),
                .i_pc    (in_pc),
                .o_valid (w_skid_valid),
                .o_instr (w_skid_instr),
                .o_pc    (w_skid_pc)
            );

            // Registered copy of (state != SKID) keeps out_ready off the in_ready path.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_next != ST_SKID);
                end
            end

            assign w_in_ready = r_in_ready;
        end else begin : g_no_skid
            logic w_unused_skid;

            assign w_unused_skid = w_skid_load ^ w_skid_clear;
            assign w_skid_valid  = 1'b0;
            assign w_skid_instr  = '0;
            assign w_skid_pc     = '0;
            assign w_in_ready    = out_ready | ~w_main_valid;
        end
    endgenerate

    assign in_ready  = w_in_ready;
    assign out_valid = w_main_valid;
    assign out_instr = w_main_valid ? w_main_instr : NOP_INSTR;
    assign out_pc    = w_main_valid ? w_main_pc    : '0;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule : fetch_decode_pipe_reg
`default_nettype wire

// File: tb/tb_fetch_decode_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_decode_pipe_reg
// Brief  : Directed and randomised checks of both skid and no-skid variants.
// Rev    : 1.0
// ============================================================================
module tb_fetch_decode_pipe_reg;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;

    logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [31:0] s_in_instr, s_in_pc, s_out_instr, s_out_pc;
    logic [1:0]  s_occ;

    logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [31:0] n_in_instr, n_in_pc, n_out_instr, n_out_pc;
    logic [1:0]  n_occ;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fetch_decode_pipe_reg #(
        .INSTR_W (32), .PC_W (32), .NOP_INSTR (c_nop), .SKID_EN (1)
    ) dut_s (
        .clk (clk), .reset (reset), .flush (s_flush),
        .in_valid (s_in_valid), .in_ready (s_in_ready),
        .in_instr (s_in_instr), .in_pc (s_in_pc),
        .out_valid (s_out_valid), .out_ready (s_out_ready),
        .out_instr (s_out_instr), .out_pc (s_out_pc),
        .occupancy (s_occ)
    );

    fetch_decode_pipe_reg #(
        .INSTR_W (32), .PC_W (32), .NOP_INSTR (c_nop), .SKID_EN (0)
    ) dut_n (
        .clk (clk), .reset (reset), .flush (n_flush),
        .in_valid (n_in_valid), .in_ready (n_in_ready),
        .in_instr (n_in_instr), .in_pc (n_in_pc),
        .out_valid (n_out_valid), .out_ready (n_out_ready),
        .out_instr (n_out_instr), .out_pc (n_out_pc),
        .occupancy (n_occ)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] f_instr(input logic [31:0] pc);
        return 32'hA500_0000 ^ pc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_s(input logic v, input logic [31:0] pc);
        s_in_valid = v;
        s_in_pc    = pc;
        s_in_instr = f_instr(pc);
    endtask

    task automatic drive_n(input logic v, input logic [31:0] pc);
        n_in_valid = v;
        n_in_pc    = pc;
        n_in_instr = f_instr(pc);
    endtask

    logic [63:0] qs[$];
    logic [63:0] qn[$];
    logic [31:0] seq_s, seq_n;
    logic        fire_i, fire_o, exp_rdy;

    initial begin
        reset = 1'b1;
        s_flush = 1'b0; s_out_ready = 1'b1; drive_s(1'b1, 32'hEE);
        n_flush = 1'b0; n_out_ready = 1'b0; drive_n(1'b1, 32'hEC);
        #3;
        chk("rst_s_valid", s_out_valid, 0);
        chk("rst_s_instr", s_out_instr, c_nop);
        chk("rst_s_pc",    s_out_pc,    0);
        chk("rst_s_occ",   s_occ,       0);
        chk("rst_s_ready", s_in_ready,  1);
        chk("rst_n_ready", n_in_ready,  1);
        chk("rst_n_valid", n_out_valid, 0);
        tick();
        chk("rst_s_hold",  s_out_valid, 0);
        reset = 1'b0;
        drive_n(1'b0, 0);

        // Streaming with decode always ready.
        drive_s(1'b1, 32'h00);
        tick();
        chk("str0_pc", s_out_pc, 32'h00);
        chk("str0_in", s_out_instr, f_instr(32'h00));
        chk("str0_occ", s_occ, 1);
        drive_s(1'b1, 32'h04);
        tick();
        chk("str1_pc", s_out_pc, 32'h04);
        chk("str1_occ", s_occ, 1);
        drive_s(1'b1, 32'h08);
        tick();
        chk("str2_pc", s_out_pc, 32'h08);
        chk("str2_rdy", s_in_ready, 1);
        drive_s(1'b0, 0);
        tick();
        chk("str_empty", s_out_valid, 0);
        chk("str_nop", s_out_instr, c_nop);

        // Backpressure fills the skid entry.
        s_out_ready = 1'b0;
        drive_s(1'b1, 32'h10);
        tick();
        chk("bp0_pc", s_out_pc, 32'h10);
        chk("bp0_rdy", s_in_ready, 1);
        drive_s(1'b1, 32'h14);
        tick();
        chk("bp1_pc", s_out_pc, 32'h10);
        chk("bp1_occ", s_occ, 2);
        chk("bp1_rdy", s_in_ready, 0);
        drive_s(1'b1, 32'h18);
        tick();
        chk("bp2_pc", s_out_pc, 32'h10);
        chk("bp2_occ", s_occ, 2);
        s_out_ready = 1'b1;
        tick();
        chk("bp3_pc", s_out_pc, 32'h14);
        chk("bp3_occ", s_occ, 1);
        chk("bp3_rdy", s_in_ready, 1);
        tick();
        chk("bp4_pc", s_out_pc, 32'h18);
        chk("bp4_in", s_out_instr, f_instr(32'h18));
        drive_s(1'b0, 0);
        tick();
        chk("bp_empty", s_out_valid, 0);

        // Flush while in SKID state.
        s_out_ready = 1'b0;
        drive_s(1'b1, 32'h30);
        tick();
        drive_s(1'b1, 32'h34);
        tick();
        chk("fl_occ2", s_occ, 2);
        drive_s(1'b1, 32'h20);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        drive_s(1'b0, 0);
        chk("fl_valid", s_out_valid, 0);
        chk("fl_occ", s_occ, 0);
        chk("fl_rdy", s_in_ready, 1);
        chk("fl_pc", s_out_pc, 0);
        tick();
        chk("fl_gone", s_out_valid, 0);

        // Flush drops an input accepted in the same cycle.
        drive_s(1'b1, 32'h40);
        tick();
        chk("fl2_pc", s_out_pc, 32'h40);
        drive_s(1'b1, 32'h44);
        s_flush = 1'b1;
        tick();
        s_flush = 1'b0;
        drive_s(1'b0, 0);
        chk("fl2_valid", s_out_valid, 0);
        tick();
        chk("fl2_gone", s_occ, 0);

        // Single-entry variant: combinational in_ready.
        drive_n(1'b1, 32'h50);
        tick();
        chk("ns0_valid", n_out_valid, 1);
        chk("ns0_pc", n_out_pc, 32'h50);
        drive_n(1'b1, 32'h54);
        #1;
        chk("ns_rdy_lo", n_in_ready, 0);
        tick();
        chk("ns1_pc", n_out_pc, 32'h50);
        n_out_ready = 1'b1;
        #1;
        chk("ns_rdy_hi", n_in_ready, 1);
        tick();
        chk("ns2_pc", n_out_pc, 32'h54);
        chk("ns2_occ", n_occ, 1);
        drive_n(1'b0, 0);
        tick();
        chk("ns_empty", n_out_valid, 0);
        chk("ns_pc0", n_out_pc, 0);

        // Randomised traffic against a FIFO scoreboard.
        s_out_ready = 1'b0;
        n_out_ready = 1'b0;
        seq_s = 32'h1000;
        seq_n = 32'h8000;
        for (int c = 0; c < 10000; c++) begin
            s_in_valid  = ($urandom_range(0, 9) < 7);
            s_out_ready = ($urandom_range(0, 9) < 6);
            s_flush     = ($urandom_range(0, 31) == 0);
            s_in_pc     = seq_s;
            s_in_instr  = $urandom;
            seq_s       = seq_s + 4;
            n_in_valid  = ($urandom_range(0, 9) < 7);
            n_out_ready = ($urandom_range(0, 9) < 6);
            n_flush     = ($urandom_range(0, 31) == 0);
            n_in_pc     = seq_n;
            n_in_instr  = $urandom;
            seq_n       = seq_n + 4;
            #2;

            exp_rdy = (qs.size() < 2);
            chk("rnd_s_occ", s_occ, qs.size());
            chk("rnd_s_vld", s_out_valid, (qs.size() > 0));
            chk("rnd_s_rdy", s_in_ready, exp_rdy);
            if (qs.size() > 0) chk("rnd_s_out", {s_out_instr, s_out_pc}, qs[0]);
            else               chk("rnd_s_nop", {s_out_instr, s_out_pc}, {c_nop, 32'h0});
            fire_i = s_in_valid && exp_rdy;
            fire_o = (qs.size() > 0) && s_out_ready;
            if (fire_o) void'(qs.pop_front());
            if (s_flush) qs.delete();
            else if (fire_i) qs.push_back({s_in_instr, s_in_pc});

            exp_rdy = n_out_ready || (qn.size() == 0);
            chk("rnd_n_occ", n_occ, qn.size());
            chk("rnd_n_rdy", n_in_ready, exp_rdy);
            if (qn.size() > 0) chk("rnd_n_out", {n_out_instr, n_out_pc}, qn[0]);
            else               chk("rnd_n_nop", {n_out_instr, n_out_pc}, {c_nop, 32'h0});
            fire_i = n_in_valid && exp_rdy;
            fire_o = (qn.size() > 0) && n_out_ready;
            if (fire_o) void'(qn.pop_front());
            if (n_flush) qn.delete();
            else if (fire_i) qn.push_back({n_in_instr, n_in_pc});

            tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_fetch_decode_pipe_reg
`default_nettype wire
